decode24_rr_ctrl: RTL and testbench
===================================

// Module: decode24_rr_ctrl
// PURPOSE
//   4-way round-robin arbiter/sequencer driving a 2-4 decoder's select (x) and enable (en) inputs.
//   Shares one decoded one-hot resource between 4 requesters; holds grant until release, request drop or timeout.
//   Inserts a one-cycle dead gap between owners. gnt mirrors the decoder output for local use and checking.
// PARAMETERS
//   HOLD_MAX  16  max consecutive grant cycles per owner; 0 = timeout disabled
//   TW        $clog2(HOLD_MAX+1)+1  hold-timer width (localparam, derived)
// PORTS
//   clk      in   1  clock; all state updates on rising edge
//   rst      in   1  synchronous reset, active-high
//   req      in   4  request per requester, level; bit i = requester i
//   rel      in   1  release by current owner, 1-cycle pulse; ignored when no owner
//   sel      out  2  decoder select (drives x); index of current/last owner
//   sel_en   out  1  decoder enable (drives en); 1 only while an owner holds the resource
//   gnt      out  4  one-hot grant; invariant gnt == (sel_en ? 4'b1<<sel : 4'b0000)
//   timeout  out  1  1-cycle pulse: owner evicted by hold timer
//   to_id    out  2  index of the evicted owner; valid while timeout=1, else holds last value
// BEHAVIOUR
//   - One clock, synchronous active-high reset. All outputs registered.
//   - Reset values: state=IDLE, sel=0, sel_en=0, gnt=0, timeout=0, to_id=0, timer=0, nxt=0.
//   - nxt (2b): highest-priority index for next arbitration. Search order nxt, nxt+1, .. mod 4.
//   - States: IDLE (no owner), OWN (owner = sel), GAP (forced 1-cycle dead slot).
//   - IDLE/GAP arbitration: req sampled at edge N; if any bit set, winner w = first set bit in
//     search order -> at N+1: state=OWN, sel=w, sel_en=1, gnt=1<<w, timer=0, nxt=w+1 mod 4.
//     If req==0: IDLE stays IDLE; GAP -> IDLE. Grant latency = 1 cycle from req.
//   - OWN: timer += 1 per cycle (saturating at TW width). Exit at edge when any of:
//       rel=1; req[sel]=0; HOLD_MAX!=0 and timer==HOLD_MAX-1.
//     On exit: state=GAP, sel_en=0, gnt=0, sel unchanged, timer=0.
//     => uninterrupted owner sees gnt high exactly HOLD_MAX cycles.
//   - timeout=1 (with to_id=sel) on the exit cycle only when exit cause is timer alone
//     (rel=0 and req[sel]=1). Simultaneous rel or req drop with expiry -> normal exit, timeout=0.
//   - Back-to-back owners: gnt low exactly 1 cycle (GAP) between grants; GAP arbitrates like IDLE.
//   - Fairness: nxt advances past winner at grant, so an evicted/released owner gets lowest priority.
//   - Requests from non-owners during OWN are not latched; only level at arbitration edge counts.
//   - rel in IDLE/GAP: ignored, no state change.
//   - rst mid-grant: next edge all reset values (gnt=0, sel_en=0, nxt=0); no timeout pulse.
//   - No X on outputs after first reset edge; gnt never has >1 bit set.
// TESTING
//   T1 rst, req=0101 held -> next cycle gnt=0001 sel=0 sel_en=1; pulse rel -> gnt=0000 1 cycle, then gnt=0100 sel=2.
//   T2 req=1111 held, rel pulsed on each grant's 2nd cycle -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
//   T3 HOLD_MAX=8, req=0010 held, rel=0 -> gnt=0010 for exactly 8 cycles; timeout=1, to_id=1 on drop cycle; regrant 0010 after 1 gap.
//   T4 owner 2 granted, req[2] drops to 0 -> gnt=0000 next edge, timeout stays 0; req=1001 then -> gnt=1000 (nxt=3).
//   T5 gnt=0100 mid-hold, rst 1 cycle with req=1111 -> gnt=0000, sel_en=0 after rst; next grant gnt=0001 (nxt=0).
//   T6 HOLD_MAX=4, rel=1 on expiry cycle -> single exit, timeout=0; HOLD_MAX=0, req held 100 cycles -> no timeout, gnt constant.

Source files
------------

// File: rtl/decode24_rr_ctrl.sv
// Round-robin sequencer for a shared 2-4 decoder: picks one of four requesters,
// drives the decoder select/enable, and forces a one-cycle dead slot between owners.
module decode24_rr_ctrl #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [1:0] sel,
    output logic       sel_en,
    output logic [3:0] gnt,
    output logic       timeout,
    output logic [1:0] to_id
);

    localparam int unsigned TW        = $clog2(HOLD_MAX + 1) + 1;
    localparam int unsigned HOLD_LAST = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic            sel_en_q, sel_en_d;
    logic [3:0]      gnt_q, gnt_d;
    logic            timeout_q, timeout_d;
    logic [1:0]      to_id_q, to_id_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      nxt_q, nxt_d;

    logic            found_c;
    logic [1:0]      win_c;
    logic [1:0]      idx_c;
    logic            expire_c;
    logic            drop_c;

    // First set request bit searching upward from nxt, wrapping mod 4.
    always_comb begin
        found_c = 1'b0;
        win_c   = nxt_q;
        idx_c   = nxt_q;
        for (int i = 0; i < 4; i++) begin
            idx_c = nxt_q + 2'(i);
            if (!found_c && req[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
    end

    assign expire_c = (HOLD_MAX != 0) && (timer_q == TW'(HOLD_LAST));
    assign drop_c   = !req[sel_q];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        sel_en_d  = sel_en_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        to_id_d   = to_id_q;
        timer_d   = timer_q;
        nxt_d     = nxt_q;

        case (state_q)
            IDLE, GAP: begin
                if (found_c) begin
                    state_d  = OWN;
                    sel_d    = win_c;
                    sel_en_d = 1'b1;
                    gnt_d    = 4'b0001 << win_c;
                    timer_d  = '0;
                    nxt_d    = win_c + 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (rel || drop_c || expire_c) begin
                    state_d  = GAP;
                    sel_en_d = 1'b0;
                    gnt_d    = 4'b0000;
                    timer_d  = '0;
                    // Only a pure timer eviction is reported as a timeout.
                    if (expire_c && !rel && !drop_c) begin
                        timeout_d = 1'b1;
                        to_id_d   = sel_q;
                    end
                end else if (timer_q != {TW{1'b1}}) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                sel_en_d = 1'b0;
                gnt_d    = 4'b0000;
                timer_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            sel_en_q  <= 1'b0;
            gnt_q     <= 4'b0000;
            timeout_q <= 1'b0;
            to_id_q   <= 2'd0;
            timer_q   <= '0;
            nxt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            sel_en_q  <= sel_en_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
            to_id_q   <= to_id_d;
            timer_q   <= timer_d;
            nxt_q     <= nxt_d;
        end
    end

    assign sel     = sel_q;
    assign sel_en  = sel_en_q;
    assign gnt     = gnt_q;
    assign timeout = timeout_q;
    assign to_id   = to_id_q;

endmodule

// File: tb/tb_decode24_rr_ctrl.sv
// Directed bench for decode24_rr_ctrl: three instances with hold limits 8, 4 and 0.
module tb_decode24_rr_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] req8 = 4'b0, req4 = 4'b0, req0 = 4'b0;
    logic       rel8 = 1'b0, rel4 = 1'b0, rel0 = 1'b0;
    logic [1:0] sel8, sel4, sel0;
    logic       en8, en4, en0;
    logic [3:0] gnt8, gnt4, gnt0;
    logic       to8, to4, to0;
    logic [1:0] id8, id4, id0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode24_rr_ctrl #(.HOLD_MAX(8)) dut8 (
        .clk(clk), .rst(rst), .req(req8), .rel(rel8),
        .sel(sel8), .sel_en(en8), .gnt(gnt8), .timeout(to8), .to_id(id8)
    );
    decode24_rr_ctrl #(.HOLD_MAX(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .rel(rel4),
        .sel(sel4), .sel_en(en4), .gnt(gnt4), .timeout(to4), .to_id(id4)
    );
    decode24_rr_ctrl #(.HOLD_MAX(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .rel(rel0),
        .sel(sel0), .sel_en(en0), .gnt(gnt0), .timeout(to0), .to_id(id0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req8 = 4'b0; req4 = 4'b0; req0 = 4'b0;
        rel8 = 1'b0; rel4 = 1'b0; rel0 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt8 !== 4'b0000 || sel8 !== 2'd0 || en8 !== 1'b0 || to8 !== 1'b0 || id8 !== 2'd0) begin
            failures++;
            $display("FAIL reset8: gnt=%b sel=%0d en=%b to=%b id=%0d want 0000/0/0/0/0", gnt8, sel8, en8, to8, id8);
        end
        checks++;
        if (gnt4 !== 4'b0000 || en4 !== 1'b0 || gnt0 !== 4'b0000 || en0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_others: gnt4=%b en4=%b gnt0=%b en0=%b want all zero", gnt4, en4, gnt0, en0);
        end
    endtask

    task automatic test_basic_release();
        do_reset();
        req8 = 4'b0101;
        tick();
        checks++;
        if (gnt8 !== 4'b0001 || sel8 !== 2'd0 || en8 !== 1'b1) begin
            failures++;
            $display("FAIL t1_grant0: gnt=%b sel=%0d en=%b want 0001/0/1", gnt8, sel8, en8);
        end
        rel8 = 1'b1;
        tick();
        rel8 = 1'b0;
        checks++;
        if (gnt8 !== 4'b0000 || en8 !== 1'b0 || sel8 !== 2'd0 || to8 !== 1'b0) begin
            failures++;
            $display("FAIL t1_gap: gnt=%b en=%b sel=%0d to=%b want 0000/0/0/0", gnt8, en8, sel8, to8);
        end
        tick();
        checks++;
        if (gnt8 !== 4'b0100 || sel8 !== 2'd2 || en8 !== 1'b1) begin
            failures++;
            $display("FAIL t1_grant2: gnt=%b sel=%0d en=%b want 0100/2/1", gnt8, sel8, en8);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        req8 = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp = 4'b0001 << k;
            tick();
            checks++;
            if (gnt8 !== exp || sel8 !== 2'(k)) begin
                failures++;
                $display("FAIL t2_grant%0d: gnt=%b sel=%0d want %b/%0d", k, gnt8, sel8, exp, k);
            end
            tick();
            checks++;
            if (gnt8 !== exp) begin
                failures++;
                $display("FAIL t2_hold%0d: gnt=%b want %b", k, gnt8, exp);
            end
            rel8 = 1'b1;
            tick();
            rel8 = 1'b0;
            checks++;
            if (gnt8 !== 4'b0000 || en8 !== 1'b0) begin
                failures++;
                $display("FAIL t2_gap%0d: gnt=%b en=%b want 0000/0", k, gnt8, en8);
            end
        end
        tick();
        checks++;
        if (gnt8 !== 4'b0001) begin
            failures++;
            $display("FAIL t2_wrap: gnt=%b want 0001", gnt8);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req8 = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (gnt8 !== 4'b0010 || to8 !== 1'b0) begin
                failures++;
                $display("FAIL t3_hold%0d: gnt=%b to=%b want 0010/0", i, gnt8, to8);
            end
        end
        tick();
        checks++;
        if (gnt8 !== 4'b0000 || to8 !== 1'b1 || id8 !== 2'd1) begin
            failures++;
            $display("FAIL t3_evict: gnt=%b to=%b id=%0d want 0000/1/1", gnt8, to8, id8);
        end
        tick();
        checks++;
        if (gnt8 !== 4'b0010 || to8 !== 1'b0 || id8 !== 2'd1) begin
            failures++;
            $display("FAIL t3_regrant: gnt=%b to=%b id=%0d want 0010/0/1", gnt8, to8, id8);
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req8 = 4'b0100;
        tick();
        checks++;
        if (gnt8 !== 4'b0100 || sel8 !== 2'd2) begin
            failures++;
            $display("FAIL t4_grant: gnt=%b sel=%0d want 0100/2", gnt8, sel8);
        end
        req8 = 4'b0000;
        tick();
        checks++;
        if (gnt8 !== 4'b0000 || to8 !== 1'b0 || sel8 !== 2'd2) begin
            failures++;
            $display("FAIL t4_drop: gnt=%b to=%b sel=%0d want 0000/0/2", gnt8, to8, sel8);
        end
        req8 = 4'b1001;
        tick();
        checks++;
        if (gnt8 !== 4'b1000 || sel8 !== 2'd3) begin
            failures++;
            $display("FAIL t4_next: gnt=%b sel=%0d want 1000/3", gnt8, sel8);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req8 = 4'b0100;
        tick();
        tick();
        checks++;
        if (gnt8 !== 4'b0100) begin
            failures++;
            $display("FAIL t5_hold: gnt=%b want 0100", gnt8);
        end
        rst  = 1'b1;
        req8 = 4'b1111;
        tick();
        rst = 1'b0;
        checks++;
        if (gnt8 !== 4'b0000 || en8 !== 1'b0 || sel8 !== 2'd0 || to8 !== 1'b0) begin
            failures++;
            $display("FAIL t5_rst: gnt=%b en=%b sel=%0d to=%b want 0000/0/0/0", gnt8, en8, sel8, to8);
        end
        tick();
        checks++;
        if (gnt8 !== 4'b0001 || sel8 !== 2'd0) begin
            failures++;
            $display("FAIL t5_after: gnt=%b sel=%0d want 0001/0", gnt8, sel8);
        end
    endtask

    task automatic test_rel_on_expiry();
        do_reset();
        req4 = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt4 !== 4'b0001 || to4 !== 1'b0) begin
                failures++;
                $display("FAIL t6_hold%0d: gnt=%b to=%b want 0001/0", i, gnt4, to4);
            end
        end
        rel4 = 1'b1;
        tick();
        rel4 = 1'b0;
        checks++;
        if (gnt4 !== 4'b0000 || to4 !== 1'b0) begin
            failures++;
            $display("FAIL t6_relexp: gnt=%b to=%b want 0000/0", gnt4, to4);
        end
        tick();
        checks++;
        if (gnt4 !== 4'b0001 || to4 !== 1'b0) begin
            failures++;
            $display("FAIL t6_regrant: gnt=%b to=%b want 0001/0", gnt4, to4);
        end
    endtask

    task automatic test_no_timeout();
        do_reset();
        req0 = 4'b1000;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (gnt0 !== 4'b1000 || to0 !== 1'b0 || sel0 !== 2'd3) begin
                failures++;
                $display("FAIL t6_hold0_%0d: gnt=%b to=%b sel=%0d want 1000/0/3", i, gnt0, to0, sel0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_release();
        test_round_robin();
        test_timeout();
        test_req_drop();
        test_mid_reset();
        test_rel_on_expiry();
        test_no_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
